// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one memory line port between I-cache and D-cache (D priority); CACHE_ARB_PERF_EN adds perf counters
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
`ifdef CACHE_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts
`endif
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic op_q, op_d;
  logic d_req, idle, serving;
  assign d_req = d_read | d_write;
  assign idle = state_q == IDLE;
  assign serving = state_q == SERVE_I || state_q == SERVE_D;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state: D wins in IDLE, serve until mem_resp, one DONE turnaround
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             state_d = d_req ? SERVE_D : i_read ? SERVE_I : IDLE;
      SERVE_I, SERVE_D: state_d = mem_resp ? DONE : state_q;
      default:          state_d = IDLE;
    endcase
  end
  // capture request on the grant so memory sees stable operands
  always_comb begin
    addr_d  = idle ? (d_req ? d_address : i_read ? i_address : addr_q) : addr_q;
    wdata_d = idle && d_req ? d_wdata : wdata_q;
    op_d    = idle ? (d_req ? d_write : i_read ? 1'b0 : op_q) : op_q;
  end
  // capture registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
    end
  // outputs decoded from state and captured op only
  always_comb begin
    mem_read    = serving & ~op_q;
    mem_write   = serving & op_q;
    mem_address = addr_q;
    mem_wdata   = wdata_q;
    i_resp      = state_q == SERVE_I && mem_resp;
    d_resp      = state_q == SERVE_D && mem_resp;
    i_rdata     = mem_rdata;
    d_rdata     = mem_rdata;
  end
`ifdef CACHE_ARB_PERF_EN
  // grant and conflict counters, wrapping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (idle && !d_req && i_read) perf_i_grants <= perf_i_grants + 32'd1;
      if (idle && d_req) perf_d_grants <= perf_d_grants + 32'd1;
      if (idle && d_req && i_read) perf_conflicts <= perf_conflicts + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and randomized self-checking bench for cache_arbiter
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  logic clk = 1'b0;
  logic rst;
  logic i_read, d_read, d_write, i_resp, d_resp, mem_read, mem_write, mem_resp;
  logic [AW-1:0] i_address, d_address, mem_address;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
`ifdef CACHE_ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_i = 0;
  int t_d = 0;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef CACHE_ARB_PERF_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32+:32] = $urandom;
    return r;
  endfunction

  task automatic quiet(input string tag);
    chk({tag, "_rd"}, mem_read, 0);
    chk({tag, "_wr"}, mem_write, 0);
    chk({tag, "_iresp"}, i_resp, 0);
    chk({tag, "_dresp"}, d_resp, 0);
  endtask

  // Called at a negedge in IDLE with the winning request already driven.
  // Memory answers on the lat-th strobe cycle with line rd.
  task automatic serve(input bit exp_d, input bit exp_w, input logic [AW-1:0] exp_a,
                       input logic [LW-1:0] exp_wd, input int lat, input logic [LW-1:0] rd);
    @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      mem_resp = (k == lat);
      mem_rdata = (k == lat) ? rd : rnd_line();
      if (exp_d) begin
        d_address = $urandom;
        d_wdata = rnd_line();
      end else i_address = $urandom;
      #1;
      chk("srv_rd", mem_read, !exp_w);
      chk("srv_wr", mem_write, exp_w);
      chk("srv_addr", mem_address, exp_a);
      if (exp_w) chk("srv_wdata", mem_wdata, exp_wd);
      chk("srv_iresp", i_resp, (k == lat) && !exp_d);
      chk("srv_dresp", d_resp, (k == lat) && exp_d);
      if (k == lat) begin
        chk("rdata_i", i_rdata, rd);
        chk("rdata_d", d_rdata, rd);
        if (exp_d) t_d = cyc; else t_i = cyc;
      end
      if (k < lat) @(negedge clk);
    end
    @(negedge clk);
    mem_resp = 1'b1;
    if (exp_d) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end else i_read = 1'b0;
    #1;
    quiet("done");
    mem_resp = 1'b0;
    @(negedge clk);
    #1;
    quiet("idle");
  endtask

  initial begin
    logic [LW-1:0] wd;
    rst = 1'b1;
    {i_read, d_read, d_write, mem_resp} = '0;
    i_address = '0;
    d_address = '0;
    d_wdata = '0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    quiet("reset");
    chk("reset_addr", mem_address, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_irdata", i_rdata, 0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      chk("reset_hold_rd", mem_read, 0);
      chk("reset_hold_wr", mem_write, 0);
    end
    // I-only read
    i_read = 1'b1;
    i_address = 32'h60;
    serve(0, 0, 32'h60, '0, 3, {32{8'hA5}});
    // simultaneous I and D read: D first
    i_read = 1'b1;
    i_address = 32'h200;
    d_read = 1'b1;
    d_address = 32'h300;
    serve(1, 0, 32'h300, '0, 2, rnd_line());
    serve(0, 0, 32'h200, '0, 1, rnd_line());
    chk("i_after_d", (t_i - t_d) >= 2, 1);
`ifdef CACHE_ARB_PERF_EN
    chk("perf_i", perf_i_grants, 2);
    chk("perf_d", perf_d_grants, 1);
    chk("perf_conf", perf_conflicts, 1);
`endif
    // D writeback with address changed mid-transaction
    wd = {8{32'h12345678}};
    d_write = 1'b1;
    d_address = 32'h100;
    d_wdata = wd;
    serve(1, 1, 32'h100, wd, 3, rnd_line());
    // read and write together is a write
    wd = rnd_line();
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 32'h140;
    d_wdata = wd;
    serve(1, 1, 32'h140, wd, 2, rnd_line());
    // randomized traffic: any D request wins, pending I follows
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] ia, da;
      bit ir, dr, dw;
      ir = 1'($urandom);
      dr = 1'($urandom);
      dw = 1'($urandom);
      if (!(ir || dr || dw)) ir = 1'b1;
      ia = $urandom;
      da = $urandom;
      wd = rnd_line();
      i_read = ir;
      d_read = dr;
      d_write = dw;
      i_address = ia;
      d_address = da;
      d_wdata = wd;
      if (dr || dw) serve(1, dw, da, wd, $urandom_range(1, 4), rnd_line());
      if (ir) serve(0, 0, ia, '0, $urandom_range(1, 4), rnd_line());
    end
    // reset during SERVE_I
    i_read = 1'b1;
    i_address = 32'h80;
    @(negedge clk);
    #1;
    chk("mid_rd_before", mem_read, 1);
    rst = 1'b1;
    #1;
    chk("mid_rd_drop", mem_read, 0);
    mem_resp = 1'b1;
    #1;
    chk("mid_no_iresp", i_resp, 0);
    @(negedge clk);
    rst = 1'b0;
    i_read = 1'b0;
    #1;
    quiet("post_rst");
    chk("post_rst_addr", mem_address, 0);
    mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    quiet("post_rst_idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
